// File: rtl/bitonic_pkg.sv
// Shared helpers and state encoding for the folded bitonic sorter.
package bitonic_pkg;

    // Ceiling log2 for elaboration-time width arithmetic.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Number of compare-exchange layers in a full bitonic network of 2**lg keys.
    function automatic int steps_of(input int lg);
        return lg * (lg + 1) / 2;
    endfunction

    // Width of the phase counter: holds 0..LG.
    function automatic int phase_w(input int num);
        return clog2(clog2(num) + 1);
    endfunction

    // Width of the step counter: holds 0..LG-1, never narrower than one bit.
    function automatic int step_w(input int num);
        return (clog2(clog2(num)) > 0) ? clog2(clog2(num)) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bitonic_cex_layer.sv
// One combinational compare-exchange layer of a bitonic network, selected by (p, j).
module bitonic_cex_layer
    import bitonic_pkg::*;
#(
    parameter int NUM = 16,
    parameter int W   = 16
) (
    input  logic [NUM*W-1:0]        data_in,
    input  logic [phase_w(NUM)-1:0] p,
    input  logic [step_w(NUM)-1:0]  j,
    input  logic                    dir,
    output logic [NUM*W-1:0]        data_out
);

    localparam int LGW = clog2(NUM);

    // Each lane computes its own result; the lower lane of a pair takes the min
    // when the pair runs ascending, the upper lane takes the min when descending.
    for (genvar i = 0; i < NUM; i++) begin : g_lane
        localparam logic [LGW:0] IDX = (LGW + 1)'(i);

        logic [LGW-1:0] lidx;
        logic [LGW-1:0] pidx;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   mn;
        logic [W-1:0]   mx;
        logic           is_lo;
        logic           asc;

        // Partner lookup and min/max selection for lane i.
        always_comb begin
            lidx  = IDX[LGW-1:0];
            pidx  = lidx ^ (LGW'(1) << j);
            a     = data_in[W*i +: W];
            b     = data_in[W*pidx +: W];
            is_lo = ~lidx[j];
            asc   = ~IDX[p] ^ dir;
            mn    = (b < a) ? b : a;
            mx    = (b < a) ? a : b;
        end

        assign data_out[W*i +: W] = (is_lo == asc) ? mn : mx;
    end

endmodule

// File: rtl/bitonic_fold_sequencer.sv
// Folded bitonic sorter: one shared compare-exchange layer stepped through every
// (phase, step) of the network, one layer per clock.
//
//   state | meaning
//   IDLE  | waiting for an input block, in_ready high
//   SORT  | applying layer (phase, step) to the data register each cycle
//   DONE  | sorted block presented on OUT until out_ready
module bitonic_fold_sequencer
    import bitonic_pkg::*;
#(
    parameter int NUM = 16,
    parameter int W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    direction,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM*W-1:0]        IN,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM*W-1:0]        OUT,
    output logic                    busy,
    output logic [phase_w(NUM)-1:0] phase,
    output logic [step_w(NUM)-1:0]  step
);

    localparam int LG = clog2(NUM);
    localparam int PW = phase_w(NUM);
    localparam int SW = step_w(NUM);

    state_t            state, state_nx;
    logic [NUM*W-1:0]  data_q, data_nx;
    logic [NUM*W-1:0]  layer_out;
    logic              dir_q, dir_nx;
    logic [PW-1:0]     p_q, p_nx;
    logic [SW-1:0]     j_q, j_nx;

    bitonic_cex_layer #(
        .NUM (NUM),
        .W   (W)
    ) u_layer (
        .data_in  (data_q),
        .p        (p_q),
        .j        (j_q),
        .dir      (dir_q),
        .data_out (layer_out)
    );

    // State, data and counter registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            data_q <= '0;
            dir_q  <= 1'b0;
            p_q    <= '0;
            j_q    <= '0;
        end else begin
            state  <= state_nx;
            data_q <= data_nx;
            dir_q  <= dir_nx;
            p_q    <= p_nx;
            j_q    <= j_nx;
        end
    end

    // Next-state, layer sequencing and handshake outputs.
    always_comb begin
        state_nx  = state;
        data_nx   = data_q;
        dir_nx    = dir_q;
        p_nx      = p_q;
        j_nx      = j_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_nx  = IN;
                    dir_nx   = direction;
                    p_nx     = PW'(1);
                    j_nx     = '0;
                    state_nx = SORT;
                end
            end
            SORT: begin
                busy    = 1'b1;
                data_nx = layer_out;
                if (j_q != '0) begin
                    j_nx = j_q - SW'(1);
                end else if (p_q < PW'(LG)) begin
                    // Next phase starts at step p-1 of the new phase, i.e. the old p.
                    p_nx = p_q + PW'(1);
                    j_nx = SW'(p_q);
                end else begin
                    p_nx     = '0;
                    j_nx     = '0;
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign OUT   = data_q;
    assign phase = p_q;
    assign step  = j_q;

endmodule

// File: doc/bitonic_fold_sequencer.md
Name: bitonic_fold_sequencer

Overview:
Folded (iterative) bitonic sorter controller. Accepts one block of NUM keys via a valid/ready handshake and holds it in an internal NUM×W register. It then steps one shared compare-exchange layer through every (phase, step) of the full bitonic network, one layer per clock, and presents the sorted block on a valid/ready output. It is the area-lean alternative to the fully unrolled, pipelined sorter stages. It trades throughput for a single comparator layer.

Parameters:
NUM, 16, keys per block; power of 2, >= 2
W, 16, key width in bits; keys are unsigned
(derived) LG = log2(NUM); STEPS = LG*(LG+1)/2 (10 for NUM=16)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
direction  in  1  0 = ascending (lane 0 smallest), 1 = descending; sampled on input accept
in_valid  in  1  input block valid
in_ready  out  1  high only in IDLE
IN  in  NUM*W  input block; lane i = IN[W*i +: W]
out_valid  out  1  sorted block available
out_ready  in  1  consumer accepts
OUT  out  NUM*W  sorted block, same lane mapping; driven from data register
busy  out  1  high in SORT or DONE
phase  out  clog2(LG+1)  current phase p (1..LG), 0 when not sorting
step  out  clog2(LG)  current step j, 0 when not sorting

Behaviour:
- Reset (rst=0, async): state=IDLE; data register=0; dir register=0; out_valid=0; in_ready=1; busy=0; phase=0; step=0; OUT=0.
- FSM IDLE -> SORT -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid: IN and direction are registered, p=1, j=0, and the state moves to SORT.
- SORT: each cycle applies layer (p,j) to the data register.
  - After layer (p,j): if j>0, then j-1. Otherwise, if p<LG, then p+1 and j=p (the new p-1). Otherwise the state moves to DONE.
- Layer (p,j): for each lane i with bit j of i = 0, the partner is k = i | (1<<j).
  - asc = (bit p of i == 0) XOR dir_reg. For p = LG, bit LG is 0, so the whole block follows dir_reg.
  - If asc: lane i gets min and lane k gets max; otherwise the reverse.
  - Compare is unsigned. Equal keys are not swapped.
- Latency: out_valid rises exactly STEPS clock edges after the accept edge (10 for NUM=16).
- DONE: out_valid=1. OUT stays stable until out_ready. On out_valid & out_ready the state moves to IDLE and out_valid drops the next cycle.
- No bypass: a new block is accepted at the earliest one cycle after the handoff. The minimum block spacing is STEPS+2 cycles.
- in_valid while not IDLE is ignored. in_ready stays 0; nothing is dropped, because the source holds the block.
- direction changes during SORT or DONE have no effect.
- rst asserted mid-SORT or in DONE: immediate return to the reset state; the partial block is discarded.
- NUM=2: STEPS=1, single layer (1,0).

Decomposition:
- Package bitonic_pkg:
  - clog2 function
  - STEPS function of LG
  - state encoding constants IDLE/SORT/DONE (2 bits)
- Sub-module bitonic_cex_layer #(NUM,W): purely combinational compare-exchange layer.
  - Inputs: data, p, j, dir.
  - Output: data.
  - Generate-loop over NUM/2 pairs.
- The sequencer holds the FSM, counters, and registers.

Test Plan:
- Reset mid-sort: accept a block, pull rst low at cycle 4 -> out_valid=0, in_ready=1, phase=0, OUT=0 asynchronously. After release, no out_valid appears.
- Ascending: NUM=16, W=16, lane i = 15-i, direction=0, out_ready=1 -> out_valid exactly 10 cycles after accept. Lane i = i. The phase/step trace is (1,0),(2,1),(2,0),(3,2),(3,1),(3,0),(4,3),(4,2),(4,1),(4,0).
- Descending: lanes = {3,0xFFFF,0,7,7,1,0,7,…}, direction=1 -> lane 0 = 0xFFFF. The output is non-increasing, the multiset is preserved, and duplicate 7s are kept.
- Backpressure: out_ready=0 for 5 cycles in DONE -> OUT stable, out_valid=1, in_ready=0. in_valid pulses and direction toggles are ignored.
- Back-to-back: in_valid held with two blocks, out_ready=1 -> the second accept occurs 12 cycles after the first (STEPS+2), and both results are correct.
- Random: 1000 blocks with random keys, random direction, and random out_ready stalls -> every output matches a software sort, and the handshake count is preserved.
